// File: rtl/bus_xfer_issuer_pkg.sv
// Shared definitions for the bus transfer issuer: bus code width, reserved
// bus codes and the issuer FSM state encoding.
package bus_xfer_issuer_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned REQ_W  = 2 * CODE_W;  // {src, dst} as stored in the request queue

  localparam logic [CODE_W-1:0] CODE_NONE = 4'd0;
  localparam logic [CODE_W-1:0] CODE_MEM  = 4'd8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDrive   = 2'd1,
    StMemWait = 2'd2
  } state_e;

endpackage

// File: rtl/xfer_req_fifo.sv
// Request queue for the bus transfer issuer: DEPTH x WIDTH synchronous FIFO
// with first-word fall-through read data.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push, i_data  write strobe and data (caller guarantees !o_full)
//   i_pop           read strobe (caller guarantees !o_empty)
//   o_data          current head entry
//   o_empty, o_full occupancy flags
module xfer_req_fifo
  import bus_xfer_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = REQ_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/bus_xfer_issuer.sv
// Initiator side of the main-bus control protocol. Queues (source, destination)
// requests and drives registered Bus_Assert/Bus_Load codes, holding them across
// memory-bridge transfers until Memory_Ack or a timeout.
// Ports:
//   Clock_In, Reset_In      clock, asynchronous active-low reset
//   Req_Valid/Req_Ready     request handshake; Req_Src/Req_Dst device codes
//   Memory_Ack              memory bridge completion (only seen in StMemWait)
//   Bus_Assert, Bus_Load    registered codes to bus control, 0 when idle
//   Busy                    FSM active or requests pending
//   Illegal_Err             1-cycle pulse when a Src==Dst!=0 request is dropped
//   Timeout_Err             1-cycle pulse when a memory transfer is aborted
module bus_xfer_issuer
  import bus_xfer_issuer_pkg::*;
#(
  parameter int unsigned       DEPTH       = 2,
  parameter logic [CODE_W-1:0] MEM_CODE    = CODE_MEM,
  parameter int unsigned       ACK_TIMEOUT = 15
) (
  input  logic              Clock_In,
  input  logic              Reset_In,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic [CODE_W-1:0] Req_Src,
  input  logic [CODE_W-1:0] Req_Dst,
  input  logic              Memory_Ack,
  output logic [CODE_W-1:0] Bus_Assert,
  output logic [CODE_W-1:0] Bus_Load,
  output logic              Busy,
  output logic              Illegal_Err,
  output logic              Timeout_Err
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_e            r_state;
  logic [CODE_W-1:0] r_assert;
  logic [CODE_W-1:0] r_load;
  logic              r_ill_err;
  logic              r_to_err;
  logic [CNT_W-1:0]  r_wait_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic [REQ_W-1:0]  w_head;
  logic [CODE_W-1:0] w_head_src;
  logic [CODE_W-1:0] w_head_dst;
  logic              w_head_illegal;
  logic              w_head_noop;
  logic              w_head_legal;
  logic              w_cur_mem;
  logic              w_deq_point;
  logic              w_issue;
  logic              w_abort;
  logic [CNT_W-1:0]  w_cnt_inc;

  xfer_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .i_clk   (Clock_In),
    .i_rst_n (Reset_In),
    .i_push  (w_push),
    .i_data  ({Req_Src, Req_Dst}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_push     = Req_Valid && !w_full;
  assign w_head_src = w_head[REQ_W-1:CODE_W];
  assign w_head_dst = w_head[CODE_W-1:0];

  assign w_head_illegal = (w_head_src == w_head_dst) && (w_head_src != CODE_NONE);
  assign w_head_noop    = (w_head_src == CODE_NONE) && (w_head_dst == CODE_NONE);
  assign w_head_legal   = !w_head_illegal && !w_head_noop;

  assign w_cur_mem = (r_assert == MEM_CODE) || (r_load == MEM_CODE);

  // Points where the current transfer (if any) is finished and the head may be taken.
  assign w_deq_point = (r_state == StIdle)
                    || ((r_state == StDrive) && !w_cur_mem)
                    || ((r_state == StMemWait) && Memory_Ack);

  // Illegal and no-op heads are also popped at a dequeue point, but not issued.
  assign w_pop   = w_deq_point && !w_empty;
  assign w_issue = w_pop && w_head_legal;

  // r_wait_cnt counts completed MEM_WAIT cycles, so MEM_WAIT lasts at most
  // ACK_TIMEOUT cycles. An ack in the last cycle still completes normally.
  assign w_cnt_inc = r_wait_cnt + CNT_W'(1);
  assign w_abort   = (r_state == StMemWait) && !Memory_Ack
                  && (w_cnt_inc == CNT_W'(ACK_TIMEOUT));

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_state    <= StIdle;
      r_assert   <= CODE_NONE;
      r_load     <= CODE_NONE;
      r_ill_err  <= 1'b0;
      r_to_err   <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_ill_err <= 1'b0;
      r_to_err  <= 1'b0;
      if (w_deq_point) begin
        if (w_issue) begin
          r_state  <= StDrive;
          r_assert <= w_head_src;
          r_load   <= w_head_dst;
        end else begin
          r_state   <= StIdle;
          r_assert  <= CODE_NONE;
          r_load    <= CODE_NONE;
          r_ill_err <= w_pop && w_head_illegal;
        end
      end else begin
        unique case (r_state)
          StDrive: begin
            // Only reached for memory transfers; codes stay as they are.
            r_state    <= StMemWait;
            r_wait_cnt <= '0;
          end
          StMemWait: begin
            if (w_abort) begin
              r_state  <= StIdle;
              r_assert <= CODE_NONE;
              r_load   <= CODE_NONE;
              r_to_err <= 1'b1;
            end else begin
              r_wait_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  assign Req_Ready   = !w_full;
  assign Bus_Assert  = r_assert;
  assign Bus_Load    = r_load;
  assign Busy        = (r_state != StIdle) || !w_empty;
  assign Illegal_Err = r_ill_err;
  assign Timeout_Err = r_to_err;

endmodule

// File: tb/tb_bus_xfer_issuer.sv
// Bench for bus_xfer_issuer. Stimulus pushes the expected bus events (transfer
// codes with hold length, error pulses) into a queue; a negedge monitor turns
// DUT outputs into events and compares them in order.
module tb_bus_xfer_issuer;
  import bus_xfer_issuer_pkg::*;

  localparam int unsigned ACK_TO = 15;

  localparam logic [1:0] K_XFER = 2'd0;
  localparam logic [1:0] K_ILL  = 2'd1;
  localparam logic [1:0] K_TO   = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] a;
    logic [3:0] l;
    logic [7:0] len;
  } ev_t;

  logic       Clock_In = 1'b0;
  logic       Reset_In;
  logic       Req_Valid;
  logic       Req_Ready;
  logic [3:0] Req_Src;
  logic [3:0] Req_Dst;
  logic       Memory_Ack;
  logic [3:0] Bus_Assert;
  logic [3:0] Bus_Load;
  logic       Busy;
  logic       Illegal_Err;
  logic       Timeout_Err;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  logic [7:0] cur_codes = 8'h00;
  int         cur_len   = 0;
  logic [7:0] mon_codes;

  always #5 Clock_In = ~Clock_In;

  bus_xfer_issuer #(
    .DEPTH       (2),
    .MEM_CODE    (4'd8),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .Clock_In    (Clock_In),
    .Reset_In    (Reset_In),
    .Req_Valid   (Req_Valid),
    .Req_Ready   (Req_Ready),
    .Req_Src     (Req_Src),
    .Req_Dst     (Req_Dst),
    .Memory_Ack  (Memory_Ack),
    .Bus_Assert  (Bus_Assert),
    .Bus_Load    (Bus_Load),
    .Busy        (Busy),
    .Illegal_Err (Illegal_Err),
    .Timeout_Err (Timeout_Err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic expect_ev(input ev_t got);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind=%0d A=%0h L=%0h len=%0d, none expected",
               got.kind, got.a, got.l, got.len);
    end else begin
      e = sb.pop_front();
      check("bus_event", 32'(got), 32'(e));
    end
  endtask

  // Monitor: a run of identical non-zero codes is one transfer.
  always @(negedge Clock_In) begin
    if (!Reset_In) begin
      cur_len = 0;
    end else begin
      mon_codes = {Bus_Assert, Bus_Load};
      if (cur_len > 0 && mon_codes != cur_codes) begin
        expect_ev({K_XFER, cur_codes[7:4], cur_codes[3:0], 8'(cur_len)});
        cur_len = 0;
      end
      if (Illegal_Err) expect_ev({K_ILL, 4'd0, 4'd0, 8'd0});
      if (Timeout_Err) expect_ev({K_TO, 4'd0, 4'd0, 8'd0});
      if (mon_codes != 8'h00) begin
        if (cur_len > 0) cur_len++;
        else begin
          cur_codes = mon_codes;
          cur_len   = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock_In);
    #1;
  endtask

  task automatic send(input logic [3:0] s, input logic [3:0] d);
    Req_Valid = 1'b1;
    Req_Src   = s;
    Req_Dst   = d;
    tick();
    Req_Valid = 1'b0;
    Req_Src   = 4'd0;
    Req_Dst   = 4'd0;
  endtask

  task automatic push_xfer(input logic [3:0] a, input logic [3:0] l, input int len);
    sb.push_back({K_XFER, a, l, 8'(len)});
  endtask

  // Returns at the negedge of the first cycle the codes are on the bus.
  task automatic wait_codes(input logic [3:0] a, input logic [3:0] l);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clock_In);
      if (Bus_Assert == a && Bus_Load == l) seen = 1'b1;
    end
    check($sformatf("wait_codes_%0h_%0h", a, l), 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_In   = 1'b0;
    Req_Valid  = 1'b0;
    Req_Src    = 4'd0;
    Req_Dst    = 4'd0;
    Memory_Ack = 1'b0;
    #12;
    check("rst_assert", 32'(Bus_Assert), 32'd0);
    check("rst_load", 32'(Bus_Load), 32'd0);
    check("rst_ready", 32'(Req_Ready), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_ill", 32'(Illegal_Err), 32'd0);
    check("rst_to", 32'(Timeout_Err), 32'd0);
    tick();
    Reset_In = 1'b1;
    tick();

    // Reset in the middle of a memory wait: outputs clear without a clock.
    send(4'd8, 4'd3);
    wait_codes(4'd8, 4'd3);
    tick();
    check("memwait_busy", 32'(Busy), 32'd1);
    tick();
    #2 Reset_In = 1'b0;
    #1;
    check("midrst_assert", 32'(Bus_Assert), 32'd0);
    check("midrst_load", 32'(Bus_Load), 32'd0);
    check("midrst_ready", 32'(Req_Ready), 32'd1);
    check("midrst_busy", 32'(Busy), 32'd0);
    tick();
    Reset_In = 1'b1;
    tick();

    // Back-to-back transfers, Memory_Ack held high to show it is ignored.
    Memory_Ack = 1'b1;
    push_xfer(4'd1, 4'd2, 1);
    push_xfer(4'd3, 4'd4, 1);
    send(4'd1, 4'd2);
    send(4'd3, 4'd4);
    wait_codes(4'd1, 4'd2);
    @(negedge Clock_In);
    check("b2b_second", 32'({Bus_Assert, Bus_Load}), 32'h34);
    tick();
    Memory_Ack = 1'b0;
    check("b2b_codes_idle", 32'({Bus_Assert, Bus_Load}), 32'h00);
    check("b2b_busy_fall", 32'(Busy), 32'd0);

    // Memory transfer acked in its third wait cycle: held 4 cycles.
    push_xfer(4'd8, 4'd1, 4);
    send(4'd8, 4'd1);
    wait_codes(4'd8, 4'd1);
    tick();
    tick();
    tick();
    Memory_Ack = 1'b1;
    tick();
    Memory_Ack = 1'b0;
    check("ack_codes_idle", 32'({Bus_Assert, Bus_Load}), 32'h00);

    // Memory transfer with no ack: aborted, then the queued request issues.
    push_xfer(4'd2, 4'd8, ACK_TO + 1);
    sb.push_back({K_TO, 4'd0, 4'd0, 8'd0});
    push_xfer(4'd6, 4'd7, 1);
    send(4'd2, 4'd8);
    wait_codes(4'd2, 4'd8);
    tick();
    send(4'd6, 4'd7);
    wait_codes(4'd6, 4'd7);
    tick();

    // Illegal request dropped, no-op dropped silently, legal one issued.
    sb.push_back({K_ILL, 4'd0, 4'd0, 8'd0});
    push_xfer(4'd1, 4'd2, 1);
    send(4'd5, 4'd5);
    send(4'd0, 4'd0);
    send(4'd1, 4'd2);
    wait_codes(4'd1, 4'd2);
    tick();

    // Fill the queue during a memory wait; ack frees a slot, order kept.
    push_xfer(4'd8, 4'd1, 6);
    push_xfer(4'd1, 4'd2, 1);
    push_xfer(4'd3, 4'd4, 1);
    send(4'd8, 4'd1);
    wait_codes(4'd8, 4'd1);
    tick();
    send(4'd1, 4'd2);
    send(4'd3, 4'd4);
    check("full_ready", 32'(Req_Ready), 32'd0);
    check("full_busy", 32'(Busy), 32'd1);
    tick();
    tick();
    Memory_Ack = 1'b1;
    tick();
    Memory_Ack = 1'b0;
    check("after_ack_ready", 32'(Req_Ready), 32'd1);
    wait_codes(4'd3, 4'd4);
    tick();
    tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
